// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit and its lane aligner.
package lsu_pkg;

   // Datapath width; the lane logic below is written for 32-bit words only.
   localparam int LSU_DATA_WIDTH = 32;

   // Access size encodings as presented by the MEM-stage control.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // FSM state encodings: IDLE serves requests, WRITE commits a merged word.
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;

   // Word-aligned memory address for a byte address.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

   // Size 11 is reserved and behaves exactly like a word access.
   function automatic logic is_word_size(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load lane extract/extend, store lane merge and
// alignment check, all driven by the low address bits and the access size.
module mem_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            addr_lo_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] mem_word_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic [DATA_WIDTH-1:0] merge_word_o,
   output logic                  misaligned_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [3:0]  byte_en;

   // Pick the addressed byte and half out of the memory word (little-endian).
   always_comb begin
      byte_lane = mem_word_i[7:0];
      case (addr_lo_i)
         2'd0:    byte_lane = mem_word_i[7:0];
         2'd1:    byte_lane = mem_word_i[15:8];
         2'd2:    byte_lane = mem_word_i[23:16];
         default: byte_lane = mem_word_i[31:24];
      endcase
      half_lane = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
   end

   // Extend the selected lane to a full word; word-sized loads pass through.
   always_comb begin
      load_data_o = mem_word_i;
      case (size_i)
         SIZE_BYTE: load_data_o = unsigned_i ? {24'b0, byte_lane}
                                             : {{24{byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_data_o = unsigned_i ? {16'b0, half_lane}
                                             : {{16{half_lane[15]}}, half_lane};
         default:   load_data_o = mem_word_i;
      endcase
   end

   // Byte enables of the lanes a store replaces.
   always_comb begin
      byte_en = 4'b1111;
      case (size_i)
         SIZE_BYTE: byte_en = 4'b0001 << addr_lo_i;
         SIZE_HALF: byte_en = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         default:   byte_en = 4'b1111;
      endcase
   end

   // Per-lane merge: enabled lanes take store data, the rest keep the old word.
   // A byte store replicates WriteData[7:0]; a half store places the low half
   // so that even lanes take bits [7:0] and odd lanes bits [15:8].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] src_byte;

         // Source byte for this lane according to the access size.
         always_comb begin
            case (size_i)
               SIZE_BYTE: src_byte = wdata_i[7:0];
               SIZE_HALF: src_byte = wdata_i[8*(gi%2) +: 8];
               default:   src_byte = wdata_i[8*gi +: 8];
            endcase
         end

         assign merge_word_o[8*gi +: 8] = byte_en[gi] ? src_byte
                                                      : mem_word_i[8*gi +: 8];
      end
   endgenerate

   // Halves need bit 0 clear, words (and reserved size) need both low bits clear.
   always_comb begin
      misaligned_o = 1'b0;
      case (size_i)
         SIZE_BYTE: misaligned_o = 1'b0;
         SIZE_HALF: misaligned_o = addr_lo_i[0];
         default:   misaligned_o = (addr_lo_i != 2'b00);
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Loads and word stores complete in one cycle; byte/half stores take a
// read cycle (stalled) followed by a write cycle of the merged word.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] Address_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic [1:0]            Size_i,
   input  logic                  Unsigned_i,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic                  Stall_o,
   output logic                  AddrError_o,
   output logic [DATA_WIDTH-1:0] BadVAddr_o,
   output logic [DATA_WIDTH-1:0] MemAddress_o,
   output logic [DATA_WIDTH-1:0] MemWriteData_o,
   output logic                  MemWrite_o,
   output logic                  MemRead_o,
   input  logic [DATA_WIDTH-1:0] MemReadData_i
);

   logic [0:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] merge_q, merge_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] bad_vaddr_q, bad_vaddr_d;

   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_word;
   logic                  misaligned;
   logic                  request;

   mem_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .addr_lo_i    (Address_i[1:0]),
      .size_i       (Size_i),
      .unsigned_i   (Unsigned_i),
      .mem_word_i   (MemReadData_i),
      .wdata_i      (WriteData_i),
      .load_data_o  (load_data),
      .merge_word_o (merge_word),
      .misaligned_o (misaligned)
   );

   assign request = MemRead_i | MemWrite_i;

   // Next-state and output decode; WRITE ignores the inputs entirely.
   always_comb begin
      state_d        = state_q;
      merge_d        = merge_q;
      addr_d         = addr_q;
      bad_vaddr_d    = bad_vaddr_q;
      ReadData_o     = '0;
      Stall_o        = 1'b0;
      AddrError_o    = 1'b0;
      MemAddress_o   = '0;
      MemWriteData_o = '0;
      MemWrite_o     = 1'b0;
      MemRead_o      = 1'b0;

      if (state_q == WRITE) begin
         // Commit the merged word; the pipeline advances at this edge.
         MemWrite_o     = 1'b1;
         MemWriteData_o = merge_q;
         MemAddress_o   = addr_q;
         state_d        = IDLE;
      end else if (request) begin
         if (misaligned) begin
            AddrError_o = 1'b1;
            bad_vaddr_d = Address_i;
         end else if (MemWrite_i) begin
            // A simultaneous read+write is a store, so ReadData stays 0.
            MemAddress_o = word_addr(Address_i);
            if (is_word_size(Size_i)) begin
               MemWrite_o     = 1'b1;
               MemWriteData_o = WriteData_i;
            end else begin
               // Read the old word now, write the merged word next cycle.
               MemRead_o = 1'b1;
               Stall_o   = 1'b1;
               merge_d   = merge_word;
               addr_d    = word_addr(Address_i);
               state_d   = WRITE;
            end
         end else begin
            MemRead_o    = 1'b1;
            MemAddress_o = word_addr(Address_i);
            ReadData_o   = load_data;
         end
      end

      // While reset is held, the memory side and the pipeline see no activity.
      if (!reset) begin
         ReadData_o     = '0;
         Stall_o        = 1'b0;
         AddrError_o    = 1'b0;
         MemAddress_o   = '0;
         MemWriteData_o = '0;
         MemWrite_o     = 1'b0;
         MemRead_o      = 1'b0;
      end
   end

   // State, merge buffer, held word address and faulting address registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         merge_q     <= '0;
         addr_q      <= '0;
         bad_vaddr_q <= '0;
      end else begin
         state_q     <= state_d;
         merge_q     <= merge_d;
         addr_q      <= addr_d;
         bad_vaddr_q <= bad_vaddr_d;
      end
   end

   assign BadVAddr_o = bad_vaddr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and
// scoreboards for expected load results and expected memory writes.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic [31:0] Address_i;
   logic [31:0] WriteData_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [1:0]  Size_i;
   logic        Unsigned_i;
   logic [31:0] ReadData_o;
   logic        Stall_o;
   logic        AddrError_o;
   logic [31:0] BadVAddr_o;
   logic [31:0] MemAddress_o;
   logic [31:0] MemWriteData_o;
   logic        MemWrite_o;
   logic        MemRead_o;
   logic [31:0] MemReadData_i;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .Address_i      (Address_i),
      .WriteData_i    (WriteData_i),
      .MemRead_i      (MemRead_i),
      .MemWrite_i     (MemWrite_i),
      .Size_i         (Size_i),
      .Unsigned_i     (Unsigned_i),
      .ReadData_o     (ReadData_o),
      .Stall_o        (Stall_o),
      .AddrError_o    (AddrError_o),
      .BadVAddr_o     (BadVAddr_o),
      .MemAddress_o   (MemAddress_o),
      .MemWriteData_o (MemWriteData_o),
      .MemWrite_o     (MemWrite_o),
      .MemRead_o      (MemRead_o),
      .MemReadData_i  (MemReadData_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory covering 0x10010000..0x1001003F, with a preload port.
   logic [31:0] mem [16];
   logic        pre_we;
   logic [3:0]  pre_idx;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (MemWrite_o)
         mem[MemAddress_o[5:2]] <= MemWriteData_o;
      else if (pre_we)
         mem[pre_idx] <= pre_data;
   end

   assign MemReadData_i = mem[MemAddress_o[5:2]];

   typedef struct {
      string       tag;
      logic [31:0] data;
   } ld_t;

   typedef struct {
      string       tag;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   ld_t ld_q[$];
   wr_t wr_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
      MemRead_i   = rd;
      MemWrite_i  = wr;
      Size_i      = sz;
      Unsigned_i  = uns;
      Address_i   = a;
      WriteData_i = wd;
   endtask

   task automatic idle_in();
      set_in(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   // Sample at the falling edge and retire scoreboard entries the DUT produced.
   task automatic sample_cycle();
      wr_t w;
      ld_t l;
      @(negedge clk);
      if (MemWrite_o === 1'b1) begin
         chk1("write_expected", (wr_q.size() != 0), 1'b1);
         if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk({w.tag, "_waddr"}, MemAddress_o, w.addr);
            chk({w.tag, "_wdata"}, MemWriteData_o, w.data);
            $display("[TB] write %s addr=%h data=%h", w.tag, MemAddress_o, MemWriteData_o);
         end
      end
      if (MemRead_o === 1'b1 && Stall_o === 1'b0 && ld_q.size() != 0) begin
         l = ld_q.pop_front();
         chk(l.tag, ReadData_o, l.data);
         $display("[TB] load %s addr=%h data=%h", l.tag, Address_i, ReadData_o);
      end else begin
         chk("rdata_zero", ReadData_o, 32'h0);
      end
   endtask

   task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
      ld_t l;
      set_in(1'b1, 1'b0, sz, uns, a, 32'h0);
      l.tag  = tag;
      l.data = exp;
      ld_q.push_back(l);
      sample_cycle();
      chk1({tag, "_stall"}, Stall_o, 1'b0);
      advance();
   endtask

   task automatic push_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.tag  = tag;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = d;
      advance();
      pre_we   = 1'b0;
   endtask

   // Two-cycle sub-word store: read+stall cycle, then the merged write cycle.
   task automatic do_sub_store(input string tag, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] merged);
      set_in(1'b0, 1'b1, sz, 1'b0, a, wd);
      push_write(tag, {a[31:2], 2'b00}, merged);
      sample_cycle();
      chk1({tag, "_c0_stall"}, Stall_o, 1'b1);
      chk1({tag, "_c0_rd"}, MemRead_o, 1'b1);
      chk1({tag, "_c0_wr"}, MemWrite_o, 1'b0);
      advance();
      sample_cycle();
      chk1({tag, "_c1_wr"}, MemWrite_o, 1'b1);
      chk1({tag, "_c1_stall"}, Stall_o, 1'b0);
      advance();
   endtask

   initial begin
      reset  = 1'b0;
      pre_we = 1'b0;
      pre_idx = 4'd0;
      pre_data = 32'h0;
      idle_in();

      // Preload memory while reset is held.
      preload(4'd0, 32'h0000FF80);
      preload(4'd1, 32'h11223344);
      preload(4'd2, 32'hAABBCCDD);
      preload(4'd3, 32'hCAFEF00D);

      // Reset state, with a sub-word store request present.
      set_in(1'b0, 1'b1, 2'b01, 1'b0, 32'h10010000, 32'h0);
      sample_cycle();
      chk1("rst_stall", Stall_o, 1'b0);
      chk1("rst_rd", MemRead_o, 1'b0);
      chk1("rst_wr", MemWrite_o, 1'b0);
      chk("rst_badvaddr", BadVAddr_o, 32'h0);
      idle_in();
      advance();
      reset = 1'b1;
      sample_cycle();
      chk1("idle_stall", Stall_o, 1'b0);
      advance();

      // Sub-word loads from 0x11223344.
      do_load("t1_lb",  2'b00, 1'b0, 32'h10010007, 32'h00000011);
      do_load("t1_lh",  2'b01, 1'b0, 32'h10010004, 32'h00003344);
      do_load("t1_lbu", 2'b00, 1'b1, 32'h10010006, 32'h00000022);
      do_load("t1_lhu_hi", 2'b01, 1'b1, 32'h10010006, 32'h00001122);

      // Sign/zero extension on 0x0000FF80.
      do_load("t2_lb",  2'b00, 1'b0, 32'h10010000, 32'hFFFFFF80);
      do_load("t2_lbu", 2'b00, 1'b1, 32'h10010000, 32'h00000080);
      do_load("t2_lh",  2'b01, 1'b0, 32'h10010000, 32'hFFFFFF80);
      do_load("t2_lhu", 2'b01, 1'b1, 32'h10010000, 32'h0000FF80);

      // SB into lane 1, then read back the merged word.
      do_sub_store("t3_sb", 2'b00, 32'h10010009, 32'hFFFFFF5A, 32'hAABB5ADD);
      idle_in();
      do_load("t3_lw", 2'b10, 1'b0, 32'h10010008, 32'hAABB5ADD);

      // SH into the upper half, then a signed half load of it.
      do_sub_store("t3_sh", 2'b01, 32'h10010006, 32'h0000BEEF, 32'hBEEF3344);
      do_load("t3_lh_hi", 2'b01, 1'b0, 32'h10010006, 32'hFFFFBEEF);

      // Misaligned word store and half load.
      set_in(1'b0, 1'b1, 2'b10, 1'b0, 32'h10010002, 32'hDEADBEEF);
      sample_cycle();
      chk1("t4_sw_err", AddrError_o, 1'b1);
      chk1("t4_sw_wr", MemWrite_o, 1'b0);
      chk1("t4_sw_stall", Stall_o, 1'b0);
      advance();
      idle_in();
      sample_cycle();
      chk("t4_sw_badvaddr", BadVAddr_o, 32'h10010002);
      chk1("t4_idle_err", AddrError_o, 1'b0);
      advance();
      do_load("t4_mem_kept", 2'b10, 1'b0, 32'h10010000, 32'h0000FF80);
      set_in(1'b1, 1'b0, 2'b01, 1'b0, 32'h10010001, 32'h0);
      sample_cycle();
      chk1("t4_lh_err", AddrError_o, 1'b1);
      chk1("t4_lh_rd", MemRead_o, 1'b0);
      advance();
      idle_in();
      sample_cycle();
      chk("t4_lh_badvaddr", BadVAddr_o, 32'h10010001);
      advance();

      // SH with reset pulled low during the WRITE cycle: store is dropped.
      set_in(1'b0, 1'b1, 2'b01, 1'b0, 32'h1001000E, 32'h00001234);
      sample_cycle();
      chk1("t5_c0_stall", Stall_o, 1'b1);
      advance();
      reset = 1'b0;
      sample_cycle();
      chk1("t5_rst_wr", MemWrite_o, 1'b0);
      chk1("t5_rst_stall", Stall_o, 1'b0);
      advance();
      idle_in();
      reset = 1'b1;
      sample_cycle();
      chk1("t5_idle_wr", MemWrite_o, 1'b0);
      chk1("t5_idle_stall", Stall_o, 1'b0);
      advance();
      do_load("t5_mem_kept", 2'b10, 1'b0, 32'h1001000C, 32'hCAFEF00D);

      // Read and write together act as a store with no load data.
      set_in(1'b1, 1'b1, 2'b10, 1'b0, 32'h1001000C, 32'h0BADF00D);
      push_write("t5_rdwr", 32'h1001000C, 32'h0BADF00D);
      sample_cycle();
      chk1("t5_rdwr_rd", MemRead_o, 1'b0);
      advance();
      idle_in();
      do_load("t5_rdwr_lw", 2'b10, 1'b0, 32'h1001000C, 32'h0BADF00D);

      // Back-to-back SB then LW: the LW follows once the stall releases.
      do_sub_store("t6_sb", 2'b00, 32'h10010000, 32'h00000077, 32'h0000FF77);
      do_load("t6_lw", 2'b10, 1'b0, 32'h10010000, 32'h0000FF77);

      idle_in();
      sample_cycle();
      chk("ld_q_drained", ld_q.size(), 32'd0);
      chk("wr_q_drained", wr_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
